// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - write-side FIFO constants, arbiter state type and index wrap helper
package fifo_pkg;

    localparam int FIFO_DEPTH = 45;
    localparam int PTR_W      = 6;
    localparam int PTR_MIN    = 9;
    localparam int PTR_MAX    = 54;

    typedef enum logic {IDLE, GRANT} wr_arb_state_t;

    // NREQ need not be a power of two, so wrap is explicit rather than by overflow
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester handshake and FIFO write-side bundle for fifo_wr_arbiter
interface fifo_wr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*DW-1:0]      req_data;
    logic [NREQ-1:0]         req_last;
    logic [NREQ-1:0]         req_ready;
    logic                    full;
    logic                    wen;
    logic [DW-1:0]           wdata;
    logic [$clog2(NREQ)-1:0] grant_id;
    logic                    busy;

    modport master (
        output req_valid, req_data, req_last, full,
        input  req_ready, wen, wdata, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, full,
        output req_ready, wen, wdata, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin picker: first set bit at or after start
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   start,
    output logic            found,
    output logic [IW-1:0]   idx
);

    always_comb begin
        int c;
        found = 1'b0;
        idx   = '0;
        c     = 0;
        for (int k = 0; k < NREQ; k++) begin
            c = (int'(start) + k) % NREQ;
            if (!found && req[IW'(c)]) begin
                found = 1'b1;
                idx   = IW'(c);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing the FIFO write port between NREQ requesters
// Optional FIFO_WR_ARB_LOCK_EN: grant is held until the owner's req_last beat transfers.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 8
) (
    input logic              wclk,
    input logic              wrst_n,
    fifo_wr_arbiter_if.slave bus
);

    localparam int IW = $clog2(NREQ);

    wr_arb_state_t state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [IW-1:0] grant_inc, pick_start, pick_idx;
    logic          pick_found;
    logic          xfer;
    logic          owner_last;
    logic          release_beat;

    assign grant_inc = IW'(wrap_inc(int'(grant_q), NREQ));

    // full is used combinationally so wen can never coincide with full=1
    always_comb begin
        bus.req_ready = '0;
        bus.wen       = 1'b0;
        bus.wdata     = '0;
        xfer          = 1'b0;
        owner_last    = 1'b0;
        if (state_q == GRANT) begin
            bus.req_ready[grant_q] = ~bus.full;
            bus.wdata              = bus.req_data[grant_q*DW +: DW];
            xfer                   = bus.req_valid[grant_q] & ~bus.full;
            owner_last             = bus.req_last[grant_q];
            bus.wen                = xfer;
        end
    end

`ifdef FIFO_WR_ARB_LOCK_EN
    assign release_beat = xfer & owner_last;
`else
    logic unused_last;
    assign unused_last  = owner_last;
    assign release_beat = xfer;
`endif

    // On release the search restarts just past the owner, so it only wins again if alone
    assign pick_start = release_beat ? grant_inc : rr_q;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req   (bus.req_valid),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        if (state_q == IDLE) begin
            if (pick_found) begin
                state_d = GRANT;
                grant_d = pick_idx;
            end
        end else if (release_beat) begin
            rr_d = grant_inc;
            if (pick_found) begin
                grant_d = pick_idx;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    assign bus.busy     = (state_q == GRANT);
    assign bus.grant_id = grant_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter against a queue-based reference model
module tb_fifo_wr_arbiter;
    import fifo_pkg::*;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    typedef struct { logic [DW-1:0] data; logic last; int gap; } beat_t;
    typedef struct { int id; logic [DW-1:0] data; int cyc; } wr_t;

    logic wclk = 1'b0;
    logic wrst_n;
    always #5 wclk = ~wclk;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();
    fifo_wr_arbiter_if #(.NREQ(3), .DW(DW))    bus3 ();

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW)) dut  (.wclk(wclk), .wrst_n(wrst_n), .bus(bus));
    fifo_wr_arbiter #(.NREQ(3), .DW(DW))    dut3 (.wclk(wclk), .wrst_n(wrst_n), .bus(bus3));

    beat_t           q[NREQ][$];
    wr_t             wlog[$];
    logic [NREQ-1:0] pres;
    int              checks = 0;
    int              errors = 0;
    int              owner, rr, fcount, rd_pct, cyc, c0;
    logic            force_full;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int first_valid(input logic [NREQ-1:0] v, input int start);
        for (int k = 0; k < NREQ; k++)
            if (v[(start + k) % NREQ]) return (start + k) % NREQ;
        return -1;
    endfunction

    function automatic bit releases(input logic last);
`ifdef FIFO_WR_ARB_LOCK_EN
        return last;
`else
        return 1'b1;
`endif
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (!pres[i] && q[i].size() > 0) begin
                if (q[i][0].gap > 0) begin
                    beat_t b;
                    b = q[i][0];
                    b.gap--;
                    q[i][0] = b;
                end else begin
                    pres[i] = 1'b1;
                end
            end
            bus.req_valid[i] = pres[i];
            if (pres[i]) begin
                bus.req_data[i*DW +: DW] = q[i][0].data;
                bus.req_last[i]          = q[i][0].last;
            end else begin
                bus.req_data[i*DW +: DW] = '0;
                bus.req_last[i]          = 1'b0;
            end
        end
        bus.full = force_full | (fcount >= FIFO_DEPTH);
    endtask

    task automatic load(input int i, input int n, input int base, input bit rand_last, input int max_gap);
        for (int k = 0; k < n; k++) begin
            beat_t b;
            b.data = DW'(base + k);
            b.last = rand_last ? ((k == n - 1) || ($urandom_range(2) == 0)) : 1'b1;
            b.gap  = int'($urandom_range(max_gap));
            q[i].push_back(b);
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) q[i].delete();
        pres       = '0;
        force_full = 1'b0;
        rd_pct     = 0;
        fcount     = 0;
        wlog.delete();
        drive();
    endtask

    // One cycle: check outputs at negedge against the model, then advance model and requesters
    task automatic step();
        logic [NREQ-1:0] v;
        logic [NREQ-1:0] e_ready;
        logic            e_busy, e_wen, e_last;
        logic [DW-1:0]   e_wdata;
        @(negedge wclk);
        v       = bus.req_valid;
        e_busy  = (owner >= 0);
        e_wen   = 1'b0;
        e_last  = 1'b0;
        e_ready = '0;
        e_wdata = '0;
        if (e_busy) begin
            e_wen          = v[owner] & ~bus.full;
            e_last         = bus.req_last[owner];
            e_ready[owner] = ~bus.full;
            e_wdata        = bus.req_data[owner*DW +: DW];
        end
        chk("busy",  32'(bus.busy),      32'(e_busy));
        chk("wen",   32'(bus.wen),       32'(e_wen));
        chk("ready", 32'(bus.req_ready), 32'(e_ready));
        chk("wdata", 32'(bus.wdata),     32'(e_wdata));
        if (e_busy) chk("grant_id", 32'(bus.grant_id), owner);
        if (bus.wen === 1'b1) wlog.push_back('{int'(bus.grant_id), bus.wdata, cyc});
        @(posedge wclk);
        #1;
        cyc++;
        if (!e_busy) begin
            owner = first_valid(v, rr);
        end else if (e_wen) begin
            void'(q[owner].pop_front());
            pres[owner] = 1'b0;
            fcount++;
            if (releases(e_last)) begin
                rr    = (owner + 1) % NREQ;
                owner = first_valid(v, rr);
            end
        end
        if (rd_pct > 0 && fcount > 0 && int'($urandom_range(99)) < rd_pct) fcount--;
        drive();
    endtask

    task automatic do_reset();
        #1 wrst_n = 1'b0;
        @(negedge wclk);
        chk("rst_wen",   32'(bus.wen),       0);
        chk("rst_busy",  32'(bus.busy),      0);
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_grant", 32'(bus.grant_id),  0);
        chk("rst_wdata", 32'(bus.wdata),     0);
        @(posedge wclk);
        #1 wrst_n = 1'b1;
        owner = -1;
        rr    = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        wrst_n         = 1'b0;
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.req_last   = '0;
        bus.full       = 1'b0;
        bus3.req_valid = '0;
        bus3.req_data  = '0;
        bus3.req_last  = '0;
        bus3.full      = 1'b0;
        force_full     = 1'b0;
        rd_pct         = 0;
        fcount         = 0;
        owner          = -1;
        rr             = 0;
        pres           = '0;
        cyc            = 0;

        @(negedge wclk);
        chk("init_wen",   32'(bus.wen),       0);
        chk("init_busy",  32'(bus.busy),      0);
        chk("init_ready", 32'(bus.req_ready), 0);
        chk("init_grant", 32'(bus.grant_id),  0);
        @(posedge wclk);
        #1 wrst_n = 1'b1;

        // All requesters valid: strict rotation, one beat per cycle
        clear_reqs();
        for (int i = 0; i < NREQ; i++) load(i, 6, i * 16, 1'b0, 0);
        drive();
        c0 = cyc;
        repeat (14) step();
        chk("t2_count", wlog.size(), 13);
        for (int k = 0; k < 12; k++) begin
            chk("t2_id",   wlog[k].id, k % 4);
            chk("t2_data", 32'(wlog[k].data), (k % 4) * 16 + k / 4);
            chk("t2_cyc",  wlog[k].cyc, c0 + 1 + k);
        end

        // Reset while beats are flowing
        do_reset();
        clear_reqs();

        // Single requester with a 3-cycle full window
        load(2, 8, 'h10, 1'b0, 0);
        drive();
        repeat (4) step();
        force_full = 1'b1;
        drive();
        repeat (3) step();
        force_full = 1'b0;
        drive();
        repeat (8) step();
        chk("t3_count", wlog.size(), 8);
        for (int k = 0; k < 8; k++) begin
            chk("t3_data", 32'(wlog[k].data), 'h10 + k);
            chk("t3_id",   wlog[k].id, 2);
        end

`ifdef FIFO_WR_ARB_LOCK_EN
        // Packet lock with an owner bubble; competitor waits for the last beat
        do_reset();
        clear_reqs();
        q[0].push_back('{8'h40, 1'b0, 0});
        q[0].push_back('{8'h41, 1'b0, 0});
        q[0].push_back('{8'h42, 1'b0, 1});
        q[0].push_back('{8'h43, 1'b1, 0});
        q[1].push_back('{8'h50, 1'b1, 0});
        q[1].push_back('{8'h51, 1'b1, 0});
        drive();
        repeat (9) step();
        chk("t4_count", wlog.size(), 6);
        for (int k = 0; k < 4; k++) begin
            chk("t4_id0",   wlog[k].id, 0);
            chk("t4_data0", 32'(wlog[k].data), 'h40 + k);
        end
        chk("t4_id1",    wlog[4].id, 1);
        chk("t4_nogap",  wlog[4].cyc, wlog[3].cyc + 1);
        chk("t4_bubble", wlog[2].cyc, wlog[1].cyc + 2);
`endif

        // Fill the FIFO with no reads, then free exactly one slot
        do_reset();
        clear_reqs();
        for (int i = 0; i < NREQ; i++) load(i, 20, int'($urandom_range(255)), 1'b1, 0);
        drive();
        repeat (60) step();
        chk("t5_fill", wlog.size(), FIFO_DEPTH);
        chk("t5_full", 32'(bus.full), 1);
        fcount--;
        drive();
        repeat (5) step();
        chk("t5_one_more", wlog.size(), FIFO_DEPTH + 1);

        // Random traffic with gaps, packet ends and reads
        do_reset();
        clear_reqs();
        rd_pct = 45;
        for (int i = 0; i < NREQ; i++) load(i, 40, int'($urandom_range(255)), 1'b1, 3);
        drive();
        repeat (400) step();
        chk("rand_progress", 32'(wlog.size() > 40), 1);

        // NREQ=3: rr pointer wrap after requester 2
        do_reset();
        clear_reqs();
        bus3.req_valid = 3'b100;
        bus3.req_data  = {8'hA1, 8'h00, 8'h00};
        bus3.req_last  = 3'b111;
        @(negedge wclk);
        chk("t6_idle", 32'(bus3.busy), 0);
        @(posedge wclk);
        #1;
        @(negedge wclk);
        chk("t6_g1_id",   32'(bus3.grant_id), 2);
        chk("t6_g1_wen",  32'(bus3.wen),      1);
        chk("t6_g1_data", 32'(bus3.wdata),    'hA1);
        @(posedge wclk);
        #1 bus3.req_data = {8'hA2, 8'h00, 8'h00};
        @(negedge wclk);
        chk("t6_regrant_id",   32'(bus3.grant_id), 2);
        chk("t6_regrant_wen",  32'(bus3.wen),      1);
        chk("t6_regrant_data", 32'(bus3.wdata),    'hA2);
        @(posedge wclk);
        #1;
        bus3.req_valid = 3'b111;
        bus3.req_data  = {8'hA3, 8'hC0, 8'hB0};
        @(negedge wclk);
        chk("t6_g3_id",  32'(bus3.grant_id), 2);
        chk("t6_g3_wen", 32'(bus3.wen),      1);
        @(posedge wclk);
        #1;
        bus3.req_valid = 3'b011;
        bus3.req_data  = {8'h00, 8'hC0, 8'hB0};
        @(negedge wclk);
        chk("t6_wrap_id",    32'(bus3.grant_id),  0);
        chk("t6_wrap_data",  32'(bus3.wdata),     'hB0);
        chk("t6_wrap_ready", 32'(bus3.req_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
